stickit_share_ctrl: RTL
=======================

// Module: stickit_share_ctrl
// PURPOSE
//  Shares one StickIt! 8-digit LED display among NREQ requesters.
//  - Each requester presents a 32-bit hex value and a request line.
//  - A round-robin arbiter grants the display to one requester for a minimum hold time.
//  - The winner's value is registered onto VALUE, which feeds the stickit scanner's VALUE input.
//  - When no requester holds the display, IDLE_VALUE is shown.
// PARAMETERS
//  NREQ        4             number of requesters, 2..8
//  HOLD        50_000_000    minimum display cycles per grant, >=1 (0.5 s at 100 MHz)
//  IDLE_VALUE  32'h0000_0000 value shown while no requester holds the display
// PORTS
//  CLK      in   1        system clock; single clock domain
//  RESET    in   1        synchronous, active-high reset
//  REQ      in   NREQ     REQ[i]=1: requester i wants the display; level-sensitive
//  DATA     in   32*NREQ  DATA[32*i+:32] is requester i's value
//  GNT      out  NREQ     one-hot grant; all zero when no requester is granted
//  VALUE    out  32       registered value to the display scanner
//  BUSY     out  1        1 when state != IDLE
// BEHAVIOUR
//  Reset values: GNT=0, VALUE=IDLE_VALUE, BUSY=0, state=IDLE, cnt=0, last=NREQ-1.
//  A RESET assertion at any point gives these values in the next cycle. No grant survives reset.
//  Arbitration (ARB) is evaluated combinationally over REQ:
//  - Search for a requesting index starting at last+1, wrapping modulo NREQ.
//  - The first index found wins.
//  - The previous owner therefore has the lowest priority.
//  State machine; all outputs are registered:
//  IDLE
//   - No REQ: stay in IDLE; VALUE=IDLE_VALUE.
//   - Any REQ in cycle t: at t+1, state=OWN, GNT=onehot(w), last=w, VALUE=DATA[w], cnt=HOLD-1.
//  OWN
//   - Every cycle: VALUE<=DATA[owner], so owner updates appear with 1-cycle latency.
//   - While cnt>0: cnt decrements by 1 per cycle.
//   - REQ[owner]=0 and cnt>0: next state=LINGER; GNT<=0; VALUE frozen.
//   - cnt==0 and another REQ pending: re-arbitrate; the new owner is granted next cycle (same as the IDLE entry).
//   - cnt==0, REQ[owner]=1 and no other REQ: stay in OWN; cnt saturates at 0.
//   - cnt==0 and REQ[owner]=0: if any REQ, grant per ARB next cycle; else go to IDLE with VALUE<=IDLE_VALUE.
//  LINGER
//   - Purpose: the minimum display time is honoured after the owner withdraws.
//   - VALUE is held and cnt decrements.
//   - All REQ lines are ignored until cnt==0. This includes the old owner re-raising REQ.
//   - At cnt==0: if any REQ, grant per ARB next cycle; else go to IDLE.
//  Invariants
//   - GNT is one-hot or zero, and is nonzero only in OWN.
//   - VALUE changes only in OWN, on grant entry, or on entry to IDLE.
//  Widths
//   - cnt is $clog2(HOLD+1) bits; unsigned; never wraps below 0.
//   - last is $clog2(NREQ) bits.
//  HOLD=1: cnt loads 0, so re-arbitration is possible one cycle after a grant.
//  REQ and DATA must be synchronous to CLK; no internal synchronisers.
// STRUCTURE
//  Shared package stickit_pkg:
//  - state encoding localparams ST_IDLE, ST_OWN, ST_LINGER
//  - the IDLE_VALUE default
//  - the 32-bit display word width
//  Sub-module stickit_rr_pick (combinational):
//  - inputs REQ and last
//  - outputs win index and any_req
//  - reused by later StickIt! sharing blocks
//  Top level holds the state register, cnt, last, and the GNT/VALUE registers.
// TESTING  (NREQ=4, HOLD=4, IDLE_VALUE=32'hDEAD_BEEF)
//  1 Reset, REQ=0 for 10 cycles -> GNT=0, BUSY=0, VALUE=DEADBEEF throughout.
//  2 REQ=4'b0001, DATA0=12345678 at t -> t+1: GNT=0001, VALUE=12345678.
//    DATA0 changed to 0000_00AA -> VALUE=0000_00AA one cycle later.
//  3 Req0 owning; REQ=4'b1011 with req0 held -> req0 owns until cnt==0, then GNT=0010.
//    After another hold, GNT=1000, then GNT=0001 (round-robin order 1,3,0).
//  4 Req0 granted at t, drops REQ at t+1 -> GNT=0 from t+2, VALUE frozen.
//    REQ2 raised at t+2 -> GNT=0100 no earlier than t+5 (LINGER honoured).
//  5 Req1 sole owner, REQ held 20 cycles -> GNT stays 0010; cnt saturates; no glitch on GNT.
//  6 RESET pulsed for 1 cycle while in OWN -> next cycle GNT=0, VALUE=DEADBEEF.
//    REQ=1111 afterwards -> GNT=0001 first (last reset to NREQ-1).
//  All tests: assert GNT one-hot or zero every cycle.

Source files
------------

// File: rtl/stickit_pkg.sv
// Shared definitions for blocks that share a StickIt! 8-digit LED display.
package stickit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_IDLE_VALUE = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LINGER = 2'd2
  } state_t;

endpackage

// File: rtl/stickit_share_ctrl_if.sv
// Requester/display bus for the shared StickIt! display controller.
interface stickit_share_ctrl_if
  import stickit_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]        REQ;
  logic [WORD_W*NREQ-1:0] DATA;
  logic [NREQ-1:0]        GNT;
  logic [WORD_W-1:0]      VALUE;
  logic                   BUSY;

  modport master (
    output REQ,
    output DATA,
    input  GNT,
    input  VALUE,
    input  BUSY
  );

  modport slave (
    input  REQ,
    input  DATA,
    output GNT,
    output VALUE,
    output BUSY
  );

endinterface

// File: rtl/stickit_rr_pick.sv
// Combinational round-robin pick: first requester after last, wrapping; last has lowest priority.
module stickit_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] win_c,
  output logic                    any_req_c
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    win_c = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = IDX_W'((int'(last) + k) % int'(NREQ));
      if (!found && req[idx]) begin
        win_c = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req_c = |req;

endmodule

// File: rtl/stickit_share_ctrl.sv
// Shares one StickIt! display among NREQ requesters with round-robin grants
// and a minimum hold time per grant, honoured even after the owner withdraws.
module stickit_share_ctrl
  import stickit_pkg::*;
#(
  parameter int unsigned       NREQ       = 4,
  parameter int unsigned       HOLD       = 50_000_000,
  parameter logic [WORD_W-1:0] IDLE_VALUE = DEFAULT_IDLE_VALUE
) (
  input  logic CLK,
  input  logic RESET,
  stickit_share_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(HOLD + 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    last, last_n;
  logic [NREQ-1:0]     gnt, gnt_n;
  logic [WORD_W-1:0]   value, value_n;
  logic                busy, busy_n;

  logic [IDX_W-1:0]    win_c;
  logic                any_req_c;
  logic                cnt_zero;
  logic                owner_req;
  logic [WORD_W-1:0]   owner_data;
  logic [WORD_W-1:0]   win_data;
  logic                do_grant;
  logic                do_idle;

  stickit_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req       (bus.REQ),
    .last      (last),
    .win_c     (win_c),
    .any_req_c (any_req_c)
  );

  assign cnt_zero   = (cnt == '0);
  assign owner_req  = bus.REQ[last];
  assign owner_data = bus.DATA[int'(last) * int'(WORD_W) +: WORD_W];
  assign win_data   = bus.DATA[int'(win_c) * int'(WORD_W) +: WORD_W];

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= IDX_W'(NREQ - 1);
      gnt   <= '0;
      value <= IDLE_VALUE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      gnt   <= gnt_n;
      value <= value_n;
      busy  <= busy_n;
    end
  end

  // Next-state: decide grant/idle per state, then apply the shared entry actions
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    gnt_n    = gnt;
    value_n  = value;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (any_req_c) do_grant = 1'b1;
        else           do_idle  = 1'b1;
      end

      ST_OWN: begin
        if (!cnt_zero) begin
          cnt_n = cnt - CNT_W'(1);
          if (!owner_req) begin
            state_n = ST_LINGER;
            gnt_n   = '0;
          end else begin
            value_n = owner_data;
          end
        end else if (owner_req && (win_c == last)) begin
          // Sole requester keeps the display; cnt stays saturated at zero
          value_n = owner_data;
        end else if (any_req_c) begin
          do_grant = 1'b1;
        end else begin
          do_idle = 1'b1;
        end
      end

      ST_LINGER: begin
        if (!cnt_zero)      cnt_n    = cnt - CNT_W'(1);
        else if (any_req_c) do_grant = 1'b1;
        else                do_idle  = 1'b1;
      end

      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_n = ST_OWN;
      gnt_n   = NREQ'(1) << win_c;
      last_n  = win_c;
      value_n = win_data;
      cnt_n   = CNT_W'(HOLD - 1);
    end else if (do_idle) begin
      state_n = ST_IDLE;
      gnt_n   = '0;
      value_n = IDLE_VALUE;
      cnt_n   = '0;
    end

    busy_n = (state_n != ST_IDLE);
  end

  assign bus.GNT   = gnt;
  assign bus.VALUE = value;
  assign bus.BUSY  = busy;

endmodule
